rst_sequencer: RTL
==================

// Module: rst_sequencer
// PURPOSE
//  Receiving end of the testbench reset interface. It takes the raw active-low reset request
//  (rst_n_req) and a software reset pulse, synchronises and de-glitches the request, and holds a
//  clean core reset for a minimum time. It then releases the switch core, followed by the switch
//  ports one at a time. It sits between the reset interface and the switch DUT reset pins.
// PARAMETERS
//  NUM_PORTS    4   number of per-port reset outputs (1..16)
//  FILT_CYC     4   consecutive synchronised-low cycles needed to accept rst_n_req (>=1)
//  HOLD_CYC     16  minimum cycles rst_n_core stays low (>=2)
//  STAGGER_CYC  2   cycles between successive releases (core->port0, port i->port i+1) (>=1)
//  CNT_W        8   width of the reset-event counter
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous, active-high power-on reset
//  rst_n_req    in   1          active-low reset request, asynchronous to clk
//  sw_rst_req   in   1          single-cycle software reset pulse, synchronous to clk
//  rst_n_core   out  1          active-low core reset, registered
//  rst_n_port   out  NUM_PORTS  active-low per-port resets, registered
//  rst_active   out  1          high while any output is in reset
//  rst_cnt      out  CNT_W      number of accepted reset triggers; saturates at all-ones
// BEHAVIOUR
//  Reset (rst=1, including mid-operation), effective at the next edge:
//   - rst_n_core=0, rst_n_port=0, rst_active=1, rst_cnt=0.
//   - FSM goes to ASSERT with the hold counter cleared; sync flops and filter counter go to
//     1 / 0 (no request).
//   - rst itself is not counted in rst_cnt.
//  Sync/filter:
//   - 2-flop synchroniser on rst_n_req.
//   - Filter counter increments on each synced-low cycle and clears on any synced-high cycle.
//   - hw_trig pulses once when the count reaches FILT_CYC. No retrigger until synced-high is seen.
//  Triggers: trig = hw_trig | sw_rst_req.
//   - Each trig increments rst_cnt (saturating). Simultaneous hw and sw triggers count once.
//  FSM states: RUN, ASSERT, REL_CORE, REL_PORTS.
//   - RUN: all outputs high, rst_active=0. On trig -> ASSERT.
//   - ASSERT: rst_n_core=0, rst_n_port=0. Hold counter counts up from 0.
//     -> REL_CORE when count >= HOLD_CYC-1 AND synced rst_n_req is high.
//     Any trig restarts the hold counter at 0.
//   - REL_CORE: rst_n_core=1 for STAGGER_CYC cycles, then -> REL_PORTS.
//   - REL_PORTS: releases port i (rst_n_port[i]=1) after STAGGER_CYC*(i+1) cycles counted from
//     the rst_n_core rise, in index order. Goes to RUN on the edge that releases port NUM_PORTS-1;
//     rst_active falls on that same edge.
//   - trig in REL_CORE or REL_PORTS -> ASSERT; rst_n_core and all rst_n_port go low on the next edge.
//  Latency:
//   - sw_rst_req high at edge e -> rst_n_core=0 after edge e+1.
//   - rst_n_req first sampled low at edge 1 and held low -> rst_n_core=0 after edge FILT_CYC+3.
//   - A low pulse shorter than FILT_CYC synced cycles is ignored: no output change, no count.
//   - The release order is strict: port i is never released before port i-1 or before the core.
//  Counters: hold counter is ceil(log2(HOLD_CYC+1)) bits; stagger counter is sized for
//   STAGGER_CYC*NUM_PORTS. Neither counter wraps.
// STRUCTURE
//  - Package switch_rst_pkg: typedef enum logic [1:0] rst_state_e {RUN, ASSERT, REL_CORE,
//    REL_PORTS}; localparam defaults for FILT_CYC, HOLD_CYC, STAGGER_CYC.
//  - Sub-module rst_sync_filter: 2-flop synchroniser plus glitch filter. Outputs hw_trig and the
//    synced level.
//  - Top level: FSM, hold/stagger counters, rst_cnt, output registers.
// TESTING
//  1. rst for 3 cycles, then release with rst_n_req=1 -> outputs low for 16 cycles (HOLD_CYC).
//     Core released, ports 0..3 released 2,4,6,8 cycles later; rst_active falls with port3;
//     rst_cnt=0.
//  2. In RUN, sw_rst_req for 1 cycle at edge e -> rst_n_core=0 after e+1; sequence repeats;
//     rst_cnt=1.
//  3. In RUN, rst_n_req low for 3 cycles -> no change, rst_cnt unchanged. Low for 40 cycles ->
//     rst_n_core=0 after edge 7; ASSERT held until synced high; rst_cnt +1 only.
//  4. sw_rst_req during REL_PORTS after port1 release -> all outputs low next edge; full sequence
//     restarts; rst_cnt +1.
//  5. sw_rst_req and hw_trig on the same edge -> rst_cnt +1 once. 300 triggers with CNT_W=8 ->
//     rst_cnt saturates at 255.
//  6. rst asserted mid-ASSERT and mid-REL_PORTS -> next edge all outputs low, rst_cnt=0, and the
//     full HOLD_CYC is re-served.

Source files
------------

// File: rtl/switch_rst_pkg.sv
// Shared state encoding and default timing for the switch reset sequencer.
// Defaults match the stock switch build; override per instance if needed.
package switch_rst_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    ASSERT    = 2'd1,
    REL_CORE  = 2'd2,
    REL_PORTS = 2'd3
  } rst_state_e;

  localparam int NUM_PORTS_DEF   = 4;
  localparam int FILT_CYC_DEF    = 4;
  localparam int HOLD_CYC_DEF    = 16;
  localparam int STAGGER_CYC_DEF = 2;
  localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/rst_sync_filter.sv
// Two-flop synchroniser and low-level glitch filter for the raw reset request.
// hw_trig is a one-cycle pulse in the cycle the filter count reaches FILT_CYC; no backpressure.
module rst_sync_filter
  import switch_rst_pkg::*;
#(
  parameter int FILT_CYC = FILT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_n_req,
  output logic hw_trig,
  output logic synced_n
);

  localparam int FW = $clog2(FILT_CYC + 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [FW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d  = rst_n_req;
    s2_d  = s1_q;
    cnt_d = cnt_q;
    if (s2_q) begin
      cnt_d = '0;
    end else if (cnt_q != FW'(FILT_CYC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count saturates at FILT_CYC, so a held-low request fires exactly once.
  assign hw_trig  = !s2_q && (cnt_q == FW'(FILT_CYC - 1));
  assign synced_n = s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds core reset >= HOLD_CYC, then releases core and ports staggered.
// Outputs are registered from the current state, one edge after a trigger; no backpressure.
module rst_sequencer
  import switch_rst_pkg::*;
#(
  parameter int NUM_PORTS   = NUM_PORTS_DEF,
  parameter int FILT_CYC    = FILT_CYC_DEF,
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int STAGGER_CYC = STAGGER_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_n_req,
  input  logic                 sw_rst_req,
  output logic                 rst_n_core,
  output logic [NUM_PORTS-1:0] rst_n_port,
  output logic                 rst_active,
  output logic [CNT_W-1:0]     rst_cnt
);

  localparam int HW      = $clog2(HOLD_CYC + 1);
  localparam int SW      = $clog2(STAGGER_CYC * NUM_PORTS + 1);
  localparam int STG_END = STAGGER_CYC * NUM_PORTS;

  logic                 hw_trig;
  logic                 synced_n;
  logic                 trig;

  rst_state_e           state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [SW-1:0]        stg_q, stg_d;
  logic                 core_q, core_d;
  logic [NUM_PORTS-1:0] port_q, port_d;
  logic                 active_q, active_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  rst_sync_filter #(
    .FILT_CYC (FILT_CYC)
  ) u_sync_filter (
    .clk       (clk),
    .rst       (rst),
    .rst_n_req (rst_n_req),
    .hw_trig   (hw_trig),
    .synced_n  (synced_n)
  );

  assign trig = hw_trig | sw_rst_req;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stg_d   = '0;
    core_d  = 1'b1;
    port_d  = '1;
    cnt_d   = cnt_q;

    if (trig && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      RUN: begin
        if (trig) begin
          state_d = ASSERT;
          hold_d  = '0;
        end
      end
      ASSERT: begin
        core_d = 1'b0;
        port_d = '0;
        if (trig) begin
          hold_d = '0;
        end else begin
          if (hold_q != HW'(HOLD_CYC)) begin
            hold_d = hold_q + 1'b1;
          end
          // Never release while the request is still held low.
          if ((hold_q >= HW'(HOLD_CYC - 1)) && synced_n) begin
            state_d = REL_CORE;
          end
        end
      end
      REL_CORE, REL_PORTS: begin
        // stg_q counts edges since entering REL_CORE; the core rose one edge later.
        stg_d = (stg_q == SW'(STG_END)) ? stg_q : stg_q + 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
          port_d[i] = (stg_q >= SW'(STAGGER_CYC * (i + 1)));
        end
        if (trig) begin
          state_d = ASSERT;
          hold_d  = '0;
        end else if (stg_q >= SW'(STG_END)) begin
          state_d = RUN;
        end else if ((state_q == REL_CORE) && (stg_q >= SW'(STAGGER_CYC))) begin
          state_d = REL_PORTS;
        end
      end
      default: begin
        state_d = ASSERT;
        hold_d  = '0;
        core_d  = 1'b0;
        port_d  = '0;
      end
    endcase

    active_d = !(core_d && (&port_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ASSERT;
      hold_q   <= '0;
      stg_q    <= '0;
      core_q   <= 1'b0;
      port_q   <= '0;
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      stg_q    <= stg_d;
      core_q   <= core_d;
      port_q   <= port_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rst_n_core = core_q;
  assign rst_n_port = port_q;
  assign rst_active = active_q;
  assign rst_cnt    = cnt_q;

endmodule
